imem_loadable: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_ram.sv | 26 ++
 rtl/imem_loadable.sv | 118 +++++++++++
 tb/tb_imem_loadable.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  function automatic int depth(input int ins_address);
    return 2 ** (ins_address - 2);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-wide program store: one synchronous write port, one registered read port.
// No reset on the array or the read register; contents are defined only by loading.
module imem_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory: load FSM, write pointer/count, range check and
// 1-cycle registered fetch port. The CPU is held stalled outside RUN.
module imem_loadable
  import imem_pkg::*;
#(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter logic [INS_W-1:0] NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [INS_W-1:0]       ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_overflow,
  output logic [INS_ADDRESS-2:0] words_loaded,
  output logic                   cpu_hold,
  input  logic                   fetch_req,
  input  logic [INS_ADDRESS-1:0] fetch_addr,
  output logic                   fetch_valid,
  output logic [INS_W-1:0]       fetch_data,
  output logic                   fetch_err
);

  localparam int                     DEPTH   = depth(INS_ADDRESS);
  localparam int                     AW      = INS_ADDRESS - 2;
  localparam logic [INS_ADDRESS-1:0] FULL    = INS_ADDRESS'(DEPTH);
  localparam logic [INS_ADDRESS-2:0] CNT_MAX = (INS_ADDRESS - 1)'(DEPTH - 1);

  state_t                   state_q;
  logic [INS_ADDRESS-1:0]   wptr_q;
  logic [INS_ADDRESS-1:0]   wptr_d;
  logic [INS_ADDRESS-2:0]   count_q;
  logic                     ovf_q;
  logic                     fvalid_q;
  logic                     ferr_q;
  logic                     fsel_q;

  logic                     full;
  logic                     beat_acc;
  logic                     fetch_fire;
  logic                     fetch_bad;
  logic [AW-1:0]            fidx;
  logic [INS_W-1:0]         ram_rdata;

  assign full       = (wptr_q == FULL);
  assign ld_ready   = (state_q == LOAD) && !full;
  assign beat_acc   = ld_ready && ld_valid && !ld_start;
  assign wptr_d     = wptr_q + 1'b1;
  assign fidx       = fetch_addr[INS_ADDRESS-1:2];
  assign fetch_fire = fetch_req && (state_q == RUN);
  // The range check uses the full-width pointer so a completely filled memory
  // still serves its last word even though words_loaded saturates one short.
  assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || ({2'b00, fidx} >= wptr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wptr_q   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      fsel_q   <= 1'b0;
    end else begin
      fvalid_q <= fetch_fire;
      if (fetch_fire) begin
        ferr_q <= fetch_bad;
        fsel_q <= !fetch_bad;
      end

      if (ld_start) begin
        state_q <= LOAD;
        wptr_q  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        case (state_q)
          LOAD: begin
            if (beat_acc) begin
              wptr_q <= wptr_d;
              if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
              if (ld_last) state_q <= RUN;
            end else if (ld_valid && full) begin
              ovf_q <= 1'b1;
              if (ld_last) state_q <= RUN;
            end
          end
          default: ;
        endcase
      end
    end
  end

  imem_ram #(
    .AW (AW),
    .DW (INS_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (beat_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (ld_data),
    .re_i    (fetch_fire),
    .raddr_i (fidx),
    .rdata_o (ram_rdata)
  );

  assign cpu_hold     = (state_q != RUN);
  assign ld_overflow  = ovf_q;
  assign words_loaded = count_q;
  assign fetch_valid  = fvalid_q;
  assign fetch_err    = ferr_q;
  // fsel_q is cleared by reset and by bad fetches, hiding the unreset RAM read.
  assign fetch_data   = fsel_q ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed self-checking bench for imem_loadable.
module tb_imem_loadable;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_overflow;
  logic [7:0]  words_loaded;
  logic        cpu_hold;
  logic        fetch_req;
  logic [8:0]  fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  imem_loadable #(
    .INS_ADDRESS (9),
    .INS_W       (32),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_start     (ld_start),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .ld_overflow  (ld_overflow),
    .words_loaded (words_loaded),
    .cpu_hold     (cpu_hold),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(input logic [8:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    tick(); tick();
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_overflow", 32'(ld_overflow), 0);
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_fvalid", 32'(fetch_valid), 0);
    chk("rst_ferr", 32'(fetch_err), 0);
    chk("rst_fdata", fetch_data, NOP);
    rst_n = 1'b1;
    tick();

    // Load a three-word program
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("load_ready", 32'(ld_ready), 1);
    chk("load_hold", 32'(cpu_hold), 1);
    beat(32'h0010_0093, 1'b0);
    beat(32'h0020_0113, 1'b0);
    chk("hold_before_last", 32'(cpu_hold), 1);
    beat(32'h0030_8193, 1'b1);
    chk("hold_after_last", 32'(cpu_hold), 0);
    chk("words_3", 32'(words_loaded), 3);
    chk("ready_in_run", 32'(ld_ready), 0);

    fetch(9'h004);
    chk("f4_valid", 32'(fetch_valid), 1);
    chk("f4_data", fetch_data, 32'h0020_0113);
    chk("f4_err", 32'(fetch_err), 0);
    tick();
    chk("idle_valid", 32'(fetch_valid), 0);
    chk("idle_hold_data", fetch_data, 32'h0020_0113);

    fetch(9'h00C);
    chk("fC_valid", 32'(fetch_valid), 1);
    chk("fC_data", fetch_data, NOP);
    chk("fC_err", 32'(fetch_err), 1);
    fetch(9'h006);
    chk("f6_data", fetch_data, NOP);
    chk("f6_err", 32'(fetch_err), 1);

    // Back-to-back fetches
    fetch_req = 1'b1; fetch_addr = 9'h000; tick();
    chk("b2b0_valid", 32'(fetch_valid), 1);
    chk("b2b0_data", fetch_data, 32'h0010_0093);
    chk("b2b0_err", 32'(fetch_err), 0);
    fetch_addr = 9'h004; tick();
    chk("b2b1_valid", 32'(fetch_valid), 1);
    chk("b2b1_data", fetch_data, 32'h0020_0113);
    fetch_addr = 9'h008; tick();
    chk("b2b2_valid", 32'(fetch_valid), 1);
    chk("b2b2_data", fetch_data, 32'h0030_8193);
    fetch_req = 1'b0; tick();
    chk("b2b_end_valid", 32'(fetch_valid), 0);

    // Reload from RUN with a simultaneous beat that must be dropped
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    chk("reload_hold", 32'(cpu_hold), 1);
    chk("reload_words", 32'(words_loaded), 0);
    chk("reload_ready", 32'(ld_ready), 1);
    beat(32'h0050_0293, 1'b1);
    chk("reload_words1", 32'(words_loaded), 1);
    chk("reload_run", 32'(cpu_hold), 0);
    fetch(9'h000);
    chk("reload_f0_data", fetch_data, 32'h0050_0293);
    chk("reload_f0_err", 32'(fetch_err), 0);
    fetch(9'h004);
    chk("reload_f4_data", fetch_data, NOP);
    chk("reload_f4_err", 32'(fetch_err), 1);

    // Fill all 128 words, then offer one more beat with last
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 128; i++) beat(32'hA000_0000 + 32'(i), 1'b0);
    chk("full_ready", 32'(ld_ready), 0);
    chk("full_words", 32'(words_loaded), 127);
    chk("full_ovf_pre", 32'(ld_overflow), 0);
    chk("full_hold", 32'(cpu_hold), 1);
    beat(32'hFFFF_FFFF, 1'b1);
    chk("ovf_flag", 32'(ld_overflow), 1);
    chk("ovf_run", 32'(cpu_hold), 0);
    fetch(9'h1FC);
    chk("ovf_f1FC_data", fetch_data, 32'hA000_007F);
    chk("ovf_f1FC_err", 32'(fetch_err), 0);
    fetch(9'h000);
    chk("ovf_f0_data", fetch_data, 32'hA000_0000);

    // Asynchronous reset in the middle of a load
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("restart_ovf_clr", 32'(ld_overflow), 0);
    beat(32'h1111_1111, 1'b0);
    beat(32'h2222_2222, 1'b0);
    chk("midload_words", 32'(words_loaded), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_words", 32'(words_loaded), 0);
    chk("arst_ready", 32'(ld_ready), 0);
    chk("arst_hold", 32'(cpu_hold), 1);
    chk("arst_fdata", fetch_data, NOP);
    chk("arst_ferr", 32'(fetch_err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // EMPTY ignores fetches and beats
    fetch(9'h000);
    chk("empty_fvalid", 32'(fetch_valid), 0);
    chk("empty_fdata", fetch_data, NOP);
    beat(32'h3333_3333, 1'b1);
    chk("empty_words", 32'(words_loaded), 0);
    chk("empty_hold", 32'(cpu_hold), 1);
    chk("empty_ready", 32'(ld_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
